// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N                = 8;
  localparam int SELW             = 3;
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux8_rr_arbiter_if;

  logic [mux8_arb_pkg::N-1:0]    req;
  logic [mux8_arb_pkg::N-1:0]    gnt;
  logic [mux8_arb_pkg::SELW-1:0] sel;
  logic                          busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick: first set request at or after 'start', wrapping 7->0.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [2*N-1:0]  doubled;
  logic [N-1:0]    rotated;
  logic [SELW-1:0] offset;

  // Bit i of the rotated vector is request (start + i) mod 8.
  assign doubled = {req, req};
  assign rotated = doubled[start +: N];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = SELW'(i);
      end
    end
  end

  assign idx = start + offset;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8-to-1 mux, with a bounded hold time.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
)
(
  input logic               clk,
  input logic               rst,
  mux8_rr_arbiter_if.slave  bus
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t      state, state_nxt;
  logic [N-1:0]    gnt, gnt_nxt;
  logic [SELW-1:0] sel, sel_nxt;
  logic [SELW-1:0] last, last_nxt;
  logic [HCW-1:0]  hold_cnt, hold_cnt_nxt;

  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic            hold_ok;

  // While granted last==sel, so starting at last+1 covers idle, release and timeout alike.
  rr_pick8 u_pick (
    .req   (bus.req),
    .start (last + 1'b1),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hold_ok = (MAX_HOLD == 0) || (int'(hold_cnt) < MAX_HOLD - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last     <= SELW'(N - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = GRANT;
          gnt_nxt      = N'(1) << pick_idx;
          sel_nxt      = pick_idx;
          last_nxt     = pick_idx;
          hold_cnt_nxt = '0;
        end
      end

      GRANT: begin
        if (bus.req[sel] && hold_ok) begin
          if (hold_cnt != {HCW{1'b1}}) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end else if (pick_found) begin
          // A timed-out owner that is the only requester wins again here.
          gnt_nxt      = N'(1) << pick_idx;
          sel_nxt      = pick_idx;
          last_nxt     = pick_idx;
          hold_cnt_nxt = '0;
        end else begin
          state_nxt    = IDLE;
          gnt_nxt      = '0;
          hold_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign bus.gnt  = gnt;
  assign bus.sel  = sel;
  assign bus.busy = |gnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter built with MAX_HOLD=4 so timeouts are reachable.
module tb_mux8_rr_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   failures;
  exp_t sbq[$];
  logic [2:0] prev_sel;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests and queue what the outputs must be after the next edge.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] eg,
                               input logic [2:0] es, input logic eb);
    exp_t e;
    @(negedge clk);
    rst     = 1'b0;
    bus.req = r;
    e.gnt   = eg;
    e.sel   = es;
    e.busy  = eb;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("gnt",  32'(bus.gnt),  32'(e.gnt));
      checkOutput("sel",  32'(bus.sel),  32'(e.sel));
      checkOutput("busy", 32'(bus.busy), 32'(e.busy));
    end
    checkOutput("inv_onehot", 32'($onehot0(bus.gnt)), 32'd1);
    checkOutput("inv_busy",   32'(bus.busy), 32'(|bus.gnt));
    if (bus.busy) begin
      checkOutput("inv_gnt_sel", 32'(bus.gnt), 32'(8'd1 << bus.sel));
    end
    if (!rst && bus.sel != prev_sel) begin
      checkOutput("inv_sel_change", 32'(bus.busy), 32'd1);
    end
    prev_sel = bus.sel;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests    = 0;
    failures = 0;
    prev_sel = '0;
    rst      = 1'b1;
    bus.req  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt",  32'(bus.gnt),  32'h0);
    checkOutput("reset_sel",  32'(bus.sel),  32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);

    // Single request, one-cycle latency, then release to idle.
    applyStimulus(8'h01, 8'h01, 3'd0, 1'b1);
    applyStimulus(8'h00, 8'h00, 3'd0, 1'b0);

    // Requesters 1,2,4,7 each drop their request while granted.
    applyStimulus(8'h96, 8'h02, 3'd1, 1'b1);
    applyStimulus(8'h94, 8'h04, 3'd2, 1'b1);
    applyStimulus(8'h92, 8'h10, 3'd4, 1'b1);
    applyStimulus(8'h86, 8'h80, 3'd7, 1'b1);
    applyStimulus(8'h16, 8'h02, 3'd1, 1'b1);
    applyStimulus(8'h00, 8'h00, 3'd1, 1'b0);

    // Leave last=6, then wrap around to 0 and 1.
    applyStimulus(8'h40, 8'h40, 3'd6, 1'b1);
    applyStimulus(8'h03, 8'h01, 3'd0, 1'b1);
    applyStimulus(8'h02, 8'h02, 3'd1, 1'b1);
    applyStimulus(8'h00, 8'h00, 3'd1, 1'b0);

    // Two persistent requesters alternate every MAX_HOLD cycles.
    for (int i = 0; i < 4; i++) applyStimulus(8'h28, 8'h08, 3'd3, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'h28, 8'h20, 3'd5, 1'b1);
    applyStimulus(8'h28, 8'h08, 3'd3, 1'b1);
    applyStimulus(8'h00, 8'h00, 3'd3, 1'b0);

    // A lone requester is re-granted through its timeouts without a gap.
    for (int i = 0; i < 12; i++) applyStimulus(8'h04, 8'h04, 3'd2, 1'b1);
    applyStimulus(8'h00, 8'h00, 3'd2, 1'b0);

    // Reset mid-grant restarts the search at requester 0.
    applyStimulus(8'h20, 8'h20, 3'd5, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_gnt",  32'(bus.gnt),  32'h0);
    checkOutput("midreset_sel",  32'(bus.sel),  32'h0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'h0);
    applyStimulus(8'h21, 8'h01, 3'd0, 1'b1);
    applyStimulus(8'h00, 8'h00, 3'd0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-to-1 mux (d[7:0], sel[2:0] -> y) among 8 requesters.
- Registers a one-hot grant and drives the mux select from it.
- Enforces a maximum hold time so that no requester can starve the others.
- Sits directly in front of mux8; its sel output connects straight to mux8.sel.

Parameters:
- N, 8, number of requesters; fixed at 8 to match the mux width.
- SELW, 3, select width; equals clog2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles per winner while others wait. 0 disables the limit.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high = requester i wants or is using the mux.
- gnt  output 8  registered one-hot grant; all zeros when idle.
- sel  output 3  registered mux select; equals the index of the set gnt bit while busy.
- busy output 1  high whenever some gnt bit is set.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-grant):
  - gnt=0, sel=0, busy=0, state=IDLE, hold_cnt=0, last=7.
  - The next search therefore starts at requester 0.
- States: IDLE, GRANT. Encoding is 1 bit.
- Search function: first set bit of req in the order last+1, last+2, ..., last+8, all mod 8. Wrap-around 7->0 is required.
- IDLE:
  - If req==0, stay in IDLE; outputs hold (sel keeps its last value, gnt=0).
  - If req!=0, pick winner w. Next edge: gnt=1<<w, sel=w, busy=1, last=w, hold_cnt=0, state=GRANT.
  - Latency is exactly 1 cycle from req sampled to gnt visible.
- GRANT, with current owner c=sel:
  - Hold: req[c]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD-1). Keep gnt/sel unchanged and increment hold_cnt.
  - Release: req[c]=0. If other requests are pending, grant the next winner (search from last=c) on the next edge with no idle bubble and hold_cnt=0. If none are pending, next edge gives gnt=0, busy=0, state=IDLE, and sel keeps c.
  - Timeout: req[c]=1 and hold_cnt==MAX_HOLD-1. Search from c+1. If another requester wins, switch to it on the next edge. If only c is requesting, re-grant c and reset hold_cnt to 0, so ownership is extended.
- Simultaneous release and new requests are resolved in the same cycle by the search. No cycle ever has two gnt bits set.
- Invariants, checked every cycle:
  - gnt is one-hot or zero.
  - busy==|gnt.
  - busy implies gnt==1<<sel.
  - sel changes only on a grant edge.
- Requests arriving mid-grant have no effect until release or timeout.
- hold_cnt width is max(1, clog2(MAX_HOLD)). It saturates and never wraps.

Decomposition:
- Shared package mux8_arb_pkg:
  - N and SELW constants.
  - State typedef (IDLE, GRANT).
  - Default MAX_HOLD.
- Sub-module rr_pick8 (purely combinational): inputs req[7:0] and start[2:0]; outputs found and idx[2:0]. Implementation is rotate, then find-first, then un-rotate.
- The top level holds the FSM, the registers and hold_cnt.

Test Plan:
- Reset then req=8'b0000_0001 -> one cycle later gnt=8'b0000_0001, sel=0, busy=1. Drop req -> next cycle gnt=0, busy=0, sel stays 0.
- req=8'b1001_0110 held, owner releases when served -> grants in order sel=1,2,4,7,1; gnt always one-hot; no idle cycle between owners.
- last=6, req=8'b0000_0011 -> wrap-around grant to sel=0, then sel=1.
- MAX_HOLD=4, req[3] and req[5] held high -> sel=3 for exactly 4 cycles, then 5 for 4 cycles, then 3 again.
- MAX_HOLD=4, only req[2] high for 12 cycles -> gnt[2] stays set continuously and busy never drops.
- Assert rst while sel=5 is granted -> next edge gnt=0, busy=0, sel=0. With req=8'b0010_0001 the next grant goes to sel=0.
